// File: rtl/game_flow_ctrl_pkg.sv
// Shared encodings for the game flow sequencer and the message renderer:
// round states and msg_sel codes, plus the state-to-message mapping.
package game_flow_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_WIN  = 2'd2,
      ST_LOSE = 2'd3
   } state_t;

   localparam logic [1:0] MSG_NONE  = 2'd0;
   localparam logic [1:0] MSG_START = 2'd1;
   localparam logic [1:0] MSG_WIN   = 2'd2;
   localparam logic [1:0] MSG_OVER  = 2'd3;

   // Message shown by the renderer while the sequencer sits in a given state
   function automatic logic [1:0] msg_of(input state_t s);
      case (s)
         ST_IDLE: return MSG_START;
         ST_PLAY: return MSG_NONE;
         ST_WIN:  return MSG_WIN;
         default: return MSG_OVER;
      endcase
   endfunction

endpackage

// File: rtl/game_flow_ctrl_sec_timer.sv
// sec_timer: one-cycle frame_tick at a fixed raster position, and a
// frame-to-second divider. sec_pulse coincides with the frame_tick that
// completes a second; clr restarts the divider from frame zero.
module sec_timer #(
   parameter int FRAMES_PER_SEC = 60,
   parameter int TICK_LINE      = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic [10:0] hcount,
   input  logic [10:0] vcount,
   output logic        frame_tick,
   output logic        sec_pulse
);

   localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);

   logic [FW-1:0] frame_cnt;

   assign sec_pulse = frame_tick && (frame_cnt == FRAME_LAST);

   // Register the raster match so the tick lands one cycle after the position
   always_ff @(posedge clk) begin
      if (rst) frame_tick <= 1'b0;
      else     frame_tick <= (hcount == 11'd0) && (vcount == 11'(TICK_LINE));
   end

   // Count frames within the current second; clr wins over a coincident tick
   always_ff @(posedge clk) begin
      if (rst || clr)  frame_cnt <= '0;
      else if (frame_tick) begin
         if (frame_cnt == FRAME_LAST) frame_cnt <= '0;
         else                         frame_cnt <= frame_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: round sequencer (IDLE/PLAY/WIN/LOSE) driving the message
// overlay, coin count and countdown timer. All outputs are registered.
// Build option: define GAME_MSG_BLINK_EN to blink the overlay in IDLE and
// LOSE every BLINK_FRAMES frame ticks; otherwise msg_visible is simply
// (msg_sel != 0) and no blink counter exists.
module game_flow_ctrl
   import game_flow_ctrl_pkg::*;
#(
   parameter int NUM_COINS      = 8,
   parameter int TIME_LIMIT_S   = 60,
   parameter int FRAMES_PER_SEC = 60,
   parameter int HOLD_S         = 3,
`ifdef GAME_MSG_BLINK_EN
   parameter int BLINK_FRAMES   = 30,
`endif
   parameter int TICK_LINE      = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount,
   input  logic [10:0] vcount,
   input  logic        start_btn,
   input  logic        coin_hit,
   input  logic        player_hit,
   output logic [3:0]  coins_left,
   output logic [6:0]  time_left,
   output logic [1:0]  msg_sel,
   output logic        msg_visible,
   output logic        game_active,
   output logic        frame_tick
);

   localparam logic [3:0] COINS_INIT = 4'(NUM_COINS);
   localparam logic [6:0] TIME_INIT  = 7'(TIME_LIMIT_S);
   localparam int HW = $clog2(HOLD_S + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_S - 1);

   state_t        state, state_nxt;
   logic          start_q, start_rise;
   logic          coin_win, time_out, hold_done;
   logic          sec_pulse, clr;
   logic [HW-1:0] hold_cnt;

   // Restarting the divider on every state change makes the WIN/LOSE hold
   // a full HOLD_S seconds no matter where in a second the round ended.
   assign clr = (state_nxt != state);

   sec_timer #(
      .FRAMES_PER_SEC (FRAMES_PER_SEC),
      .TICK_LINE      (TICK_LINE)
   ) u_sec_timer (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .hcount     (hcount),
      .vcount     (vcount),
      .frame_tick (frame_tick),
      .sec_pulse  (sec_pulse)
   );

   // Next-state decode; a winning coin beats any coincident lose event
   always_comb begin
      start_rise = start_btn && !start_q;
      coin_win   = coin_hit && (coins_left == 4'd1);
      time_out   = sec_pulse && (time_left == 7'd1);
      hold_done  = sec_pulse && (hold_cnt == HOLD_LAST);
      state_nxt  = state;
      case (state)
         ST_IDLE: if (start_rise) state_nxt = ST_PLAY;
         ST_PLAY: begin
            if (coin_win)                    state_nxt = ST_WIN;
            else if (player_hit || time_out) state_nxt = ST_LOSE;
         end
         default: if (hold_done) state_nxt = ST_IDLE;
      endcase
   end

   // State register, round counters and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         start_q     <= 1'b0;
         coins_left  <= COINS_INIT;
         time_left   <= TIME_INIT;
         hold_cnt    <= '0;
         msg_sel     <= MSG_START;
         game_active <= 1'b0;
      end else begin
         state       <= state_nxt;
         start_q     <= start_btn;
         msg_sel     <= msg_of(state_nxt);
         game_active <= (state_nxt == ST_PLAY);

         if (state_nxt != state)
            hold_cnt <= '0;
         else if ((state == ST_WIN || state == ST_LOSE) && sec_pulse)
            hold_cnt <= hold_cnt + 1'b1;

         case (state)
            ST_IDLE: begin
               if (start_rise) begin
                  coins_left <= COINS_INIT;
                  time_left  <= TIME_INIT;
               end
            end
            ST_PLAY: begin
               if (coin_hit && coins_left != 4'd0) coins_left <= coins_left - 1'b1;
               if (sec_pulse && time_left != 7'd0) time_left  <= time_left - 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef GAME_MSG_BLINK_EN
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   logic [BW-1:0] blink_cnt;

   // Blink in IDLE/LOSE, restarting visible on every state entry
   always_ff @(posedge clk) begin
      if (rst) begin
         msg_visible <= 1'b1;
         blink_cnt   <= '0;
      end else if (state_nxt != state) begin
         msg_visible <= (state_nxt != ST_PLAY);
         blink_cnt   <= '0;
      end else if ((state == ST_IDLE || state == ST_LOSE) && frame_tick) begin
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            msg_visible <= ~msg_visible;
         end else begin
            blink_cnt   <= blink_cnt + 1'b1;
         end
      end
   end
`else
   // Overlay shown whenever a message is selected
   always_ff @(posedge clk) begin
      if (rst) msg_visible <= 1'b1;
      else     msg_visible <= (msg_of(state_nxt) != MSG_NONE);
   end
`endif

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with a small configuration
// (2 frames/s, 3 s rounds, 2 s hold, 3 coins). Expected outputs are queued
// as each step is driven and popped once the DUT has clocked it.
module tb_game_flow_ctrl;

   logic        clk = 1'b0;
   logic        rst, start_btn, coin_hit, player_hit;
   logic [10:0] hcount, vcount;
   logic [3:0]  coins_left;
   logic [6:0]  time_left;
   logic [1:0]  msg_sel;
   logic        msg_visible, game_active, frame_tick;

   int passed = 0;
   int total  = 0;

   typedef struct {
      string tag;
      int    c;
      int    t;
      int    m;
      int    a;
      int    v;
   } exp_t;

   exp_t sb[$];

   game_flow_ctrl #(
      .NUM_COINS      (3),
      .TIME_LIMIT_S   (3),
      .FRAMES_PER_SEC (2),
      .HOLD_S         (2),
`ifdef GAME_MSG_BLINK_EN
      .BLINK_FRAMES   (2),
`endif
      .TICK_LINE      (480)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .hcount      (hcount),
      .vcount      (vcount),
      .start_btn   (start_btn),
      .coin_hit    (coin_hit),
      .player_hit  (player_hit),
      .coins_left  (coins_left),
      .time_left   (time_left),
      .msg_sel     (msg_sel),
      .msg_visible (msg_visible),
      .game_active (game_active),
      .frame_tick  (frame_tick)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
   endtask

   // Visibility expected for a message code; blinking messages are only
   // checked where the frame phase is known (-1 = not checked)
   function automatic int vd(input int m);
`ifdef GAME_MSG_BLINK_EN
      return (m == 1 || m == 3) ? -1 : int'(m != 0);
`else
      return int'(m != 0);
`endif
   endfunction

   function automatic int blink_pat(input int i);
`ifdef GAME_MSG_BLINK_EN
      return (i == 1 || i == 2) ? 0 : 1;
`else
      return (i >= 0) ? 1 : 0;
`endif
   endfunction

   task automatic push_exp(input string tag, input int c, t, m, a, input int v = -2);
      exp_t e;
      e.tag = tag; e.c = c; e.t = t; e.m = m; e.a = a;
      e.v = (v == -2) ? vd(m) : v;
      sb.push_back(e);
   endtask

   task automatic check_st();
      exp_t e;
      if (sb.size() == 0) begin
         total = total + 1;
         $error("FAIL scoreboard: got empty queue, want an entry");
      end else begin
         e = sb.pop_front();
         cmp({e.tag, ".coins"},  32'(coins_left),  e.c);
         cmp({e.tag, ".time"},   32'(time_left),   e.t);
         cmp({e.tag, ".msg"},    32'(msg_sel),     e.m);
         cmp({e.tag, ".active"}, 32'(game_active), e.a);
         if (e.v >= 0) cmp({e.tag, ".visible"}, 32'(msg_visible), e.v);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One frame: raster hits the tick position for a cycle, tick follows
   task automatic frame();
      hcount = 11'd0; vcount = 11'd480;
      cyc();
      hcount = 11'd1; vcount = 11'd0;
      cmp("frame_tick.hi", 32'(frame_tick), 1);
      cyc();
      cmp("frame_tick.lo", 32'(frame_tick), 0);
   endtask

   task automatic step_cyc(input string tag, input int c, t, m, a, input int v = -2);
      push_exp(tag, c, t, m, a, v);
      cyc();
      check_st();
   endtask

   task automatic step_frame(input string tag, input int c, t, m, a, input int v = -2);
      push_exp(tag, c, t, m, a, v);
      frame();
      check_st();
   endtask

   initial begin
      // reset, with the raster parked on the tick position
      rst = 1'b1; start_btn = 1'b0; coin_hit = 1'b0; player_hit = 1'b0;
      hcount = 11'd0; vcount = 11'd480;
      push_exp("reset", 3, 3, 1, 0);
      cyc(); cyc();
      check_st();
      cmp("reset.frame_tick", 32'(frame_tick), 0);
      hcount = 11'd1; vcount = 11'd0;
      rst = 1'b0;

      // start held 5 cycles: a single entry into PLAY
      start_btn = 1'b1;
      for (int i = 0; i < 5; i++) step_cyc($sformatf("start_hold%0d", i), 3, 3, 0, 1);
      start_btn = 1'b0;

      // three back-to-back coins -> WIN; inputs ignored during hold
      coin_hit = 1'b1;
      step_cyc("coin1", 2, 3, 0, 1);
      step_cyc("coin2", 1, 3, 0, 1);
      step_cyc("coin3_win", 0, 3, 2, 0);
      start_btn = 1'b1;
      step_cyc("win_ignore", 0, 3, 2, 0);
      coin_hit = 1'b0; start_btn = 1'b0;
      for (int i = 0; i < 3; i++) step_frame($sformatf("win_hold%0d", i), 0, 3, 2, 0);
      step_frame("win_to_idle", 0, 3, 1, 0);
      coin_hit = 1'b1; player_hit = 1'b1;
      step_cyc("idle_ignore", 0, 3, 1, 0);
      coin_hit = 1'b0; player_hit = 1'b0;

      // timeout: time_left drops every 2nd frame, LOSE at zero
      start_btn = 1'b1;
      step_cyc("t_start", 3, 3, 0, 1);
      start_btn = 1'b0;
      step_frame("t_f1", 3, 3, 0, 1);
      step_frame("t_f2", 3, 2, 0, 1);
      step_frame("t_f3", 3, 2, 0, 1);
      step_frame("t_f4", 3, 1, 0, 1);
      step_frame("t_f5", 3, 1, 0, 1);
      step_frame("t_f6_lose", 3, 0, 3, 0);
      for (int i = 0; i < 3; i++) step_frame($sformatf("lose_hold%0d", i), 3, 0, 3, 0);
      step_frame("lose_to_idle", 3, 0, 1, 0);

      // last coin together with the last second -> WIN wins
      start_btn = 1'b1;
      step_cyc("p_start", 3, 3, 0, 1);
      start_btn = 1'b0;
      coin_hit = 1'b1;
      step_cyc("p_coin1", 2, 3, 0, 1);
      step_cyc("p_coin2", 1, 3, 0, 1);
      coin_hit = 1'b0;
      step_frame("p_f1", 1, 3, 0, 1);
      step_frame("p_f2", 1, 2, 0, 1);
      step_frame("p_f3", 1, 2, 0, 1);
      step_frame("p_f4", 1, 1, 0, 1);
      step_frame("p_f5", 1, 1, 0, 1);
      hcount = 11'd0; vcount = 11'd480;
      cyc();
      hcount = 11'd1; vcount = 11'd0;
      cmp("p_f6.frame_tick", 32'(frame_tick), 1);
      coin_hit = 1'b1;
      step_cyc("p_win_prio", 0, 0, 2, 0);
      coin_hit = 1'b0;
      for (int i = 0; i < 3; i++) step_frame($sformatf("p_hold%0d", i), 0, 0, 2, 0);
      step_frame("p_to_idle", 0, 0, 1, 0);

      // player caught -> LOSE on the next edge
      start_btn = 1'b1;
      step_cyc("h_start", 3, 3, 0, 1);
      start_btn = 1'b0;
      player_hit = 1'b1;
      step_cyc("h_lose", 3, 3, 3, 0);
      player_hit = 1'b0;
      for (int i = 0; i < 3; i++) step_frame($sformatf("h_hold%0d", i), 3, 3, 3, 0);
      step_frame("h_to_idle", 3, 3, 1, 0);

      // reset in the middle of a round
      start_btn = 1'b1;
      step_cyc("r_start", 3, 3, 0, 1);
      start_btn = 1'b0;
      coin_hit = 1'b1;
      step_cyc("r_coin", 2, 3, 0, 1);
      coin_hit = 1'b0;
      rst = 1'b1;
      step_cyc("r_reset", 3, 3, 1, 0, 1);
      rst = 1'b0;

      // IDLE overlay visibility across frame ticks
      for (int i = 0; i < 4; i++)
         step_frame($sformatf("idle_vis%0d", i), 3, 3, 1, 0, blink_pat(i));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
